mem_io_responder: RTL and testbench

//  Bus responder for the CPU byte bus (address, data-out, data-in, write strobe): the memory/IO side.
//  - Serves 128KB RAM with 1-cycle registered read latency (CPU samples data the cycle after the address).
//  - Maps the I/O window a[17:16]==2'b11: UART byte in/out at 0x30000, cycle counter at 0x30004-7,

---
 rtl/mem_io_responder_pkg.sv | 7 +
 rtl/mem_io_responder_sync_fifo.sv | 34 +++
 rtl/mem_io_responder.sv | 76 +++++++
 tb/tb_mem_io_responder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// mem_io_responder_pkg: I/O window decode constants and responder FSM states
package mem_io_responder_pkg;
  localparam logic [1:0] IO_BASE_HI = 2'b11;
  localparam logic [2:0] OFF_UART = 3'd0;
  localparam logic [2:0] OFF_CNT = 3'd4;
  typedef enum logic [1:0] {RUN, STOP_PUSH, STOP_DRAIN, HALTED} state_t;
endpackage

// File: rtl/mem_io_responder_sync_fifo.sv
// mem_io_responder_sync_fifo: show-ahead FIFO, push honoured when full if a pop frees a slot
module mem_io_responder_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop & !empty;
  assign do_push = push & (!full | do_pop);
  assign head = empty ? '0 : mem[rp[AW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU byte-bus RAM plus UART/counter/stop I/O window with registered reads
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int    ADDR_W    = 17,
  parameter int    TX_DEPTH  = 16,
  parameter string INIT_FILE = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] bus_a,
  input  logic        bus_wr,
  input  logic [7:0]  bus_wdata,
  output logic [7:0]  bus_rdata,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_overflow,
  output logic        prog_done
);
  logic [7:0] ram [2**ADDR_W];
  state_t state, state_nx;
  logic [31:0] counter;
  logic [31:8] cnt_latch;
  logic [2:0] off;
  logic [7:0] io_byte, push_data;
  logic io_sel, cnt_rd, user_push, push, pop, full, empty, unused_a;
  assign unused_a = ^bus_a[31:18];
  assign io_sel = bus_a[17:16] == IO_BASE_HI;
  assign off = bus_a[2:0];
  assign rx_ready = !bus_wr & io_sel & (off == OFF_UART) & rx_valid;
  assign cnt_rd = !bus_wr & io_sel & (off == OFF_CNT);
  assign user_push = bus_wr & (state == RUN) & io_sel & (off == OFF_UART) & (|bus_wdata);
  // the stop marker 0x00 bypasses the zero filter and is retried until it fits
  assign push = user_push | (state == STOP_PUSH);
  assign push_data = (state == STOP_PUSH) ? 8'h00 : bus_wdata;
  assign pop = tx_valid & tx_ready;
  assign tx_valid = !empty;
  assign prog_done = state == HALTED;
  always_comb begin
    io_byte = off == OFF_UART ? (rx_valid ? rx_data : 8'h00) :
              off == OFF_CNT  ? counter[7:0] :
              off == 3'd5     ? cnt_latch[15:8] :
              off == 3'd6     ? cnt_latch[23:16] :
              off == 3'd7     ? cnt_latch[31:24] : 8'h00;
  end
  always_comb begin
    state_nx = state;
    state_nx = (state == RUN && bus_wr && io_sel && off == OFF_CNT) ? STOP_PUSH :
               (state == STOP_PUSH && (!full || pop))             ? STOP_DRAIN :
               (state == STOP_DRAIN && empty)                     ? HALTED : state;
  end
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= RUN;
      counter <= '0;
      cnt_latch <= '0;
      bus_rdata <= '0;
      tx_overflow <= 1'b0;
    end else begin
      state <= state_nx;
      counter <= counter + 32'd1;
      if (cnt_rd) cnt_latch <= counter[31:8];
      if (!bus_wr) bus_rdata <= io_sel ? io_byte : ram[bus_a[ADDR_W-1:0]];
      if (user_push && full && !pop) tx_overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk_in) if (bus_wr && state == RUN && !io_sel) ram[bus_a[ADDR_W-1:0]] <= bus_wdata;
  mem_io_responder_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk_in), .rst(rst_in), .push(push), .pop(pop), .din(push_data),
    .head(tx_data), .full(full), .empty(empty)
  );
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: randomized + directed bench, queue scoreboard against a byte-level reference model
module tb_mem_io_responder;
  logic clk_in, rst_in, bus_wr, rx_valid, rx_ready, tx_valid, tx_ready, tx_overflow, prog_done;
  logic [31:0] bus_a;
  logic [7:0] bus_wdata, bus_rdata, rx_data, tx_data;
  int tests = 0, fails = 0;
  logic [7:0] rd_q[$], tx_q[$];
  logic [7:0] mem_m [int];
  int occ, mstate;
  bit ovf, chk_en, pend;
  int unsigned cyc;
  logic [31:0] latch_m;
  localparam logic [31:0] IDLE = 32'h30001;
  mem_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .bus_a(bus_a), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_overflow(tx_overflow),
    .prog_done(prog_done)
  );
  initial clk_in = 0;
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in or posedge rst_in) cyc <= rst_in ? 0 : cyc + 1;
  always @(posedge clk_in) pend <= chk_en && !rst_in;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endfunction
  // monitor: registered read data and every byte the UART accepts
  always @(negedge clk_in) begin
    if (pend) begin
      if (rd_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rdata_unexpected: got %h with no expectation", bus_rdata);
      end else chk("rdata", bus_rdata, rd_q.pop_front());
    end
    if (tx_valid && tx_ready && !rst_in) begin
      if (tx_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL tx_extra: got %h with no byte expected", tx_data);
      end else chk("tx_data", tx_data, tx_q.pop_front());
    end
  end
  task automatic step(bit wr, logic [31:0] a, logic [7:0] wd, bit txr, bit rxv, logic [7:0] rxd, bit chk_rd);
    bit io, c, p, u;
    logic [2:0] o;
    logic [7:0] e;
    int idx, ns;
    io = a[17:16] == 2'b11;
    o = a[2:0];
    idx = int'(a[16:0]);
    c = chk_rd && !wr && (io || mem_m.exists(idx));
    bus_wr = wr; bus_a = a; bus_wdata = wd; tx_ready = txr; rx_valid = rxv; rx_data = rxd; chk_en = c;
    @(negedge clk_in);
    chk("rx_ready", rx_ready, !wr && io && o == 0 && rxv);
    chk("tx_valid", tx_valid, occ > 0);
    chk("tx_overflow", tx_overflow, ovf);
    chk("prog_done", prog_done, mstate == 3);
    if (!wr) begin
      if (!io) e = mem_m.exists(idx) ? mem_m[idx] : 8'h00;
      else if (o == 0) e = rxv ? rxd : 8'h00;
      else if (o == 4) e = cyc[7:0];
      else if (o == 5) e = latch_m[15:8];
      else if (o == 6) e = latch_m[23:16];
      else if (o == 7) e = latch_m[31:24];
      else e = 8'h00;
      if (io && o == 4) latch_m = cyc;
      if (c) rd_q.push_back(e);
    end
    p = occ > 0 && txr;
    u = wr && mstate == 0 && io && o == 0 && wd != 0;
    ns = mstate;
    if (wr && mstate == 0 && !io) mem_m[idx] = wd;
    if (wr && mstate == 0 && io && o == 4) ns = 1;
    if (u) begin
      if (occ < 16 || p) begin tx_q.push_back(wd); occ++; end
      else ovf = 1;
    end
    if (mstate == 1 && (occ < 16 || p)) begin tx_q.push_back(8'h00); occ++; ns = 2; end
    if (mstate == 2 && occ == 0) ns = 3;
    if (p) occ--;
    mstate = ns;
    @(posedge clk_in);
    #1;
  endtask
  task automatic do_reset();
    step(1, IDLE, 0, 0, 0, 0, 0);
    rst_in = 1;
    #2;
    chk("rst_rdata", bus_rdata, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_overflow", tx_overflow, 0);
    chk("rst_prog_done", prog_done, 0);
    rd_q.delete(); tx_q.delete();
    occ = 0; ovf = 0; mstate = 0; latch_m = 0;
    @(negedge clk_in);
    rst_in = 0;
    @(posedge clk_in);
    #1;
  endtask
  task automatic drain(int budget);
    for (int i = 0; i < budget && (occ > 0 || mstate == 1 || mstate == 2); i++) step(1, IDLE, 0, 1, 0, 0, 0);
    chk("drained", tx_q.size(), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] addrs [8];
    addrs = '{32'h0, 32'h10, 32'h0ABCD, 32'h2ABCD, 32'h1FFFF, 32'h10000, 32'h12345, 32'hABC12345};
    rst_in = 1; bus_wr = 1; bus_a = IDLE; bus_wdata = 0; tx_ready = 0; rx_valid = 0; rx_data = 0;
    chk_en = 0; occ = 0; ovf = 0; mstate = 0; latch_m = 0;
    do_reset();
    step(1, 32'h10, 8'hA5, 0, 0, 0, 0);
    step(0, 32'h10, 0, 0, 0, 0, 1);
    step(1, IDLE, 0, 0, 0, 0, 0);
    step(1, 32'h30000, 8'h41, 1, 0, 0, 0);
    step(1, 32'h30000, 8'h00, 1, 0, 0, 0);
    step(1, 32'h30000, 8'h42, 1, 0, 0, 0);
    drain(10);
    step(0, 32'h30000, 0, 0, 1, 8'h7E, 1);
    step(0, 32'h30000, 0, 0, 0, 8'h7E, 1);
    step(1, IDLE, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 17; i++) step(1, 32'h30000, 8'(i + 1), 0, 0, 0, 0);
    step(1, IDLE, 0, 0, 0, 0, 0);
    chk("overflow_set", tx_overflow, 1);
    drain(40);
    do_reset();
    for (int i = 0; i < 1000 && cyc != 32'h1FF; i++) step(1, IDLE, 0, 0, 0, 0, 0);
    step(0, 32'h30004, 0, 0, 0, 0, 1);
    repeat (3) step(1, IDLE, 0, 0, 0, 0, 0);
    step(0, 32'h30005, 0, 0, 0, 0, 1);
    repeat (7) step(1, IDLE, 0, 0, 0, 0, 0);
    step(0, 32'h30006, 0, 0, 0, 0, 1);
    step(0, 32'h30007, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, addrs[i], 8'($urandom), 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      int unsigned op, r;
      bit txr;
      op = $urandom % 6;
      r = $urandom % 8;
      txr = 1'($urandom % 2);
      case (op)
        0: step(1, addrs[r], 8'($urandom), txr, 0, 0, 0);
        1: step(0, addrs[r], 0, txr, 0, 0, 1);
        2: step(1, ($urandom & 32'hFFFC0000) | 32'h30000, ($urandom % 4 == 0) ? 8'h00 : 8'($urandom), txr, 0, 0, 0);
        3: step(0, 32'h30000, 0, txr, 1'($urandom % 2), 8'($urandom), 1);
        4: step(0, 32'h30004 + ($urandom % 4), 0, txr, 0, 0, 1);
        default: step(1'($urandom % 2), 32'h30001 + ($urandom % 3), 8'($urandom), txr, 0, 0, 1);
      endcase
    end
    drain(40);
    step(1, IDLE, 0, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 32'h30000, 8'(8'h80 + i), 0, 0, 0, 0);
    step(1, 32'h30004, 8'h99, 0, 0, 0, 0);
    repeat (5) step(1, IDLE, 0, 0, 0, 0, 0);
    drain(40);
    repeat (2) step(1, IDLE, 0, 1, 0, 0, 0);
    chk("halted", prog_done, 1);
    step(1, 32'h10, 8'h5A, 1, 0, 0, 0);
    step(1, 32'h30000, 8'h33, 1, 0, 0, 0);
    step(0, 32'h10, 0, 1, 0, 0, 1);
    repeat (2) step(1, IDLE, 0, 1, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
